location_streamer: RTL

LOCATION_STREAMER -- requirements
Module: location_streamer

---
 rtl/location_streamer.sv | 77 +++++++
 1 files changed

// File: rtl/location_streamer.sv
// location_streamer: snapshots a sprite location array on frame_start and streams it
// one coordinate per ready/valid transfer, dimension-minor, with frame/overrun counters.
module location_streamer #(
   parameter int SPRITES    = 3,
   parameter int DIMENSIONS = 2,
   parameter int WIDTH      = 32,
   localparam int SW = (SPRITES > 1) ? $clog2(SPRITES) : 1,
   localparam int DW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1
) (
   input  logic                                        clk,
   input  logic                                        rst_l,
   input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] locations,
   input  logic                                        frame_start,
   input  logic                                        out_ready,
   output logic                                        out_valid,
   output logic [WIDTH-1:0]                            out_data,
   output logic [SW-1:0]                               out_sprite,
   output logic [DW-1:0]                               out_dim,
   output logic                                        out_last,
   output logic                                        done,
   output logic [7:0]                                  overruns,
   output logic [15:0]                                 frames_sent
);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t r_state, w_next;
   logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] r_snap;
   logic [SW-1:0] r_sprite;
   logic [DW-1:0] r_dim;
   logic          r_done;
   logic [7:0]    r_overruns;
   logic [15:0]   r_frames;
   logic          w_xfer, w_end, w_take, w_ovr;

   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) r_state <= IDLE;
      else r_state <= w_next;

   // A request on the final transfer restarts without an idle cycle; any other request while streaming is dropped.
   always_comb begin
      w_xfer = out_valid & out_ready;
      w_end  = w_xfer & out_last;
      w_take = frame_start & ((r_state == IDLE) | w_end);
      w_ovr  = frame_start & (r_state == STREAM) & ~w_end;
      w_next = w_take ? STREAM : (w_end ? IDLE : r_state);
   end

   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
         r_snap     <= '0;
         r_sprite   <= '0;
         r_dim      <= '0;
         r_done     <= 1'b0;
         r_overruns <= '0;
         r_frames   <= '0;
      end else begin
         r_done <= w_end;
         if (w_end) r_frames <= r_frames + 16'd1;
         if (w_ovr && r_overruns != 8'hFF) r_overruns <= r_overruns + 8'd1;
         if (w_take) r_snap <= locations;
         if (w_take || w_end) begin
            r_sprite <= '0;
            r_dim    <= '0;
         end else if (w_xfer) begin
            r_dim    <= (r_dim == DW'(DIMENSIONS-1)) ? '0 : r_dim + DW'(1);
            r_sprite <= (r_dim == DW'(DIMENSIONS-1)) ? r_sprite + SW'(1) : r_sprite;
         end
      end

   assign out_valid   = (r_state == STREAM);
   assign out_data    = out_valid ? r_snap[r_sprite][r_dim] : '0;
   assign out_sprite  = r_sprite;
   assign out_dim     = r_dim;
   assign out_last    = out_valid & (r_sprite == SW'(SPRITES-1)) & (r_dim == DW'(DIMENSIONS-1));
   assign done        = r_done;
   assign overruns    = r_overruns;
   assign frames_sent = r_frames;
endmodule
